crc_engine: RTL and testbench

- Byte-serial, table-driven CRC engine.
- Generalises the fixed 8-bit CRC lookup ROM to any CRC width (8..32) with configurable init value, final XOR and input/output reflection.
- The 256-entry table ROM is generated at elaboration.
- Accepts a framed byte stream over a valid/ready handshake and presents each frame's CRC on a valid/ready result port.

---
 rtl/crc_engine.sv | 146 ++++++++++++++
 tb/tb_crc_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// crc_engine: byte-serial, table-driven CRC engine.
//
// A 256 x WIDTH lookup table is built at elaboration from POLYNOMIAL and read
// synchronously, so each byte takes two cycles: READY presents the table
// address, UPDATE folds the table word into the running register. The final
// byte of a frame (last_i) moves the engine to DONE, where the reflected and
// XORed result is held on crc_o until the consumer takes it.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   clear_i            synchronous abort of the current frame and result
//   data_i, last_i     input byte and end-of-frame marker
//   valid_i, ready_o   byte handshake
//   crc_o              frame CRC, stable while crc_valid_o is high
//   crc_valid_o        crc_o holds a completed result
//   crc_ready_i        consumer accepts crc_o
module crc_engine #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] POLYNOMIAL  = WIDTH'(8'h07),
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter logic [WIDTH-1:0] XOR_OUT     = '0,
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [7:0]       data_i,
    input  logic             last_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] crc_o,
    output logic             crc_valid_o,
    input  logic             crc_ready_i
);

    typedef enum logic [1:0] {S_READY, S_UPDATE, S_DONE} state_t;

    // Table entry: the index byte aligned to the register top, then eight
    // MSB-first shift/XOR steps.
    function automatic logic [WIDTH-1:0] table_entry(input int idx);
        logic [WIDTH-1:0] v;
        v = '0;
        v[WIDTH-1 -: 8] = idx[7:0];
        for (int k = 0; k < 8; k++) begin
            if (v[WIDTH-1]) v = (v << 1) ^ POLYNOMIAL;
            else            v = v << 1;
        end
        return v;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] revw(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        for (int k = 0; k < WIDTH; k++) r[k] = b[WIDTH-1-k];
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] crc, crc_next, crc_fin;
    logic [WIDTH-1:0] rom [256];
    logic [WIDTH-1:0] rom_q;
    logic [7:0]       byte_in, addr;
    logic             last_lat;
    logic             ready, accept, reload;

    for (genvar i = 0; i < 256; i++) begin : g_rom
        assign rom[i] = table_entry(i);
    end

    // Reflection is wiring only; no added latency.
    assign byte_in  = REFLECT_IN ? rev8(data_i) : data_i;
    assign addr     = crc[WIDTH-1 -: 8] ^ byte_in;
    // For WIDTH=8 the shift drops every bit, leaving only the table word.
    assign crc_next = (crc << 8) ^ rom_q;
    assign crc_fin  = (REFLECT_OUT ? revw(crc_next) : crc_next) ^ XOR_OUT;

    // Always-enabled synchronous ROM read. In READY the address is formed
    // from the live register, which does not change until UPDATE consumes
    // the read word.
    always_ff @(posedge clk_i) begin
        rom_q <= rom[addr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_READY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        reload    = 1'b0;
        if (clear_i) begin
            // Abort wins over everything, including a pending byte.
            state_nxt = S_READY;
            reload    = 1'b1;
        end else begin
            case (state)
                S_READY: begin
                    ready = 1'b1;
                    if (valid_i) begin
                        accept    = 1'b1;
                        state_nxt = S_UPDATE;
                    end
                end
                S_UPDATE: state_nxt = last_lat ? S_DONE : S_READY;
                S_DONE: begin
                    if (crc_ready_i) begin
                        state_nxt = S_READY;
                        reload    = 1'b1;
                    end
                end
                default: state_nxt = S_READY;
            endcase
        end
    end

    assign ready_o     = ready;
    assign crc_valid_o = (state == S_DONE);

    // crc_o is only written when a frame completes, so it holds through
    // DONE and survives a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc      <= INIT;
            crc_o    <= '0;
            last_lat <= 1'b0;
        end else if (reload) begin
            crc <= INIT;
        end else begin
            if (accept) last_lat <= last_i;
            if (state == S_UPDATE) begin
                crc <= crc_next;
                if (last_lat) crc_o <= crc_fin;
            end
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: three instances (CRC-8, CRC-16/CCITT-FALSE, CRC-32)
// driven in lockstep from one byte stream. Expected CRCs come from a table of
// known values plus a bit-serial reference model; they are queued per
// instance when a frame is sent and popped when the result is handshaken.
module tb_crc_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear, last, valid, crc_ready;
    logic [7:0]  data;
    logic        rdy8, rdy16, rdy32, cv8, cv16, cv32;
    logic [7:0]  crc8;
    logic [15:0] crc16;
    logic [31:0] crc32;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp8[$], exp16[$], exp32[$];

    always #5 clk = ~clk;

    crc_engine #(.WIDTH(8), .POLYNOMIAL(8'h07)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
        .last_i(last), .valid_i(valid), .ready_o(rdy8), .crc_o(crc8),
        .crc_valid_o(cv8), .crc_ready_i(crc_ready));

    crc_engine #(.WIDTH(16), .POLYNOMIAL(16'h1021), .INIT(16'hFFFF)) u16 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
        .last_i(last), .valid_i(valid), .ready_o(rdy16), .crc_o(crc16),
        .crc_valid_o(cv16), .crc_ready_i(crc_ready));

    crc_engine #(.WIDTH(32), .POLYNOMIAL(32'h04C11DB7), .INIT(32'hFFFFFFFF),
                 .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .data_i(data),
        .last_i(last), .valid_i(valid), .ready_o(rdy32), .crc_o(crc32),
        .crc_valid_o(cv32), .crc_ready_i(crc_ready));

    // Bit-serial reference: byte i of d sits in d[8*i +: 8].
    function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input bit ri, input bit ro,
                                            input logic [71:0] d, input int n);
        logic [31:0] c, mask, r;
        logic [7:0]  b;
        logic        fb;
        mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        c = init;
        for (int i = 0; i < n; i++) begin
            b = d[8*i +: 8];
            if (ri) for (int k = 0; k < 8; k++) b[k] = d[8*i + 7 - k];
            for (int k = 7; k >= 0; k--) begin
                fb = c[w-1] ^ b[k];
                c  = (c << 1) & mask;
                if (fb) c = c ^ poly;
            end
        end
        if (ro) begin
            r = '0;
            for (int k = 0; k < w; k++) r[w-1-k] = c[k];
            c = r;
        end
        return c ^ xo;
    endfunction

    function automatic logic [31:0] m8(input logic [71:0] d, input int n);
        return crc_ref(8, 32'h07, 32'h0, 32'h0, 1'b0, 1'b0, d, n);
    endfunction
    function automatic logic [31:0] m16(input logic [71:0] d, input int n);
        return crc_ref(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0, d, n);
    endfunction
    function automatic logic [31:0] m32(input logic [71:0] d, input int n);
        return crc_ref(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, d, n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_model(input logic [71:0] d, input int n);
        exp8.push_back(m8(d, n));
        exp16.push_back(m16(d, n));
        exp32.push_back(m32(d, n));
    endtask

    // Offer n bytes; returns at posedge+1 after the last accepted byte.
    task automatic send_bytes(input logic [71:0] d, input int n, input bit with_last);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            data  = d[8*i +: 8];
            last  = with_last && (i == n - 1);
            valid = 1'b1;
            acc   = 1'b0;
            t     = 0;
            while (!acc && t < 100) begin
                @(negedge clk);
                acc = rdy8;
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0d not accepted, expected accept within 100 cycles", i);
            end
        end
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp8.size() != 0 || exp16.size() != 0 || exp32.size() != 0) && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (exp8.size() != 0 || exp16.size() != 0 || exp32.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0",
                     exp8.size() + exp16.size() + exp32.size());
        end
    endtask

    // Scoreboard: compare on each result handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && crc_ready === 1'b1) begin
            if (cv8) begin
                if (exp8.size() == 0) chk("crc8_unexpected", 32'h1, 32'h0);
                else                  chk("crc8", {24'h0, crc8}, exp8.pop_front());
            end
            if (cv16) begin
                if (exp16.size() == 0) chk("crc16_unexpected", 32'h1, 32'h0);
                else                   chk("crc16", {16'h0, crc16}, exp16.pop_front());
            end
            if (cv32) begin
                if (exp32.size() == 0) chk("crc32_unexpected", 32'h1, 32'h0);
                else                   chk("crc32", crc32, exp32.pop_front());
            end
        end
    end

    typedef struct {
        logic [71:0] data;
        int          n;
        logic [31:0] e8, e16, e32;
    } vec_t;

    localparam logic [71:0] CHK9 = 72'h393837363534333231;  // "123456789"
    localparam logic [71:0] MIX5 = 72'h3CFF005AA5;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{72'h01, 1, 32'h07, m16(72'h01, 1), m32(72'h01, 1)};
        tbl[1] = '{72'h00, 1, 32'h00, m16(72'h00, 1), m32(72'h00, 1)};
        tbl[2] = '{72'hFF, 1, 32'hF3, m16(72'hFF, 1), m32(72'hFF, 1)};
        tbl[3] = '{CHK9,   9, 32'hF4, 32'h29B1, 32'hCBF43926};
        tbl[4] = '{CHK9,   9, 32'hF4, 32'h29B1, 32'hCBF43926};  // back-to-back: INIT reload
        tbl[5] = '{MIX5,   5, m8(MIX5, 5), m16(MIX5, 5), m32(MIX5, 5)};

        rst_n = 1'b0; clear = 1'b0; last = 1'b0; valid = 1'b0;
        crc_ready = 1'b0; data = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_ready",    {31'h0, rdy8},  32'h1);
        chk("rst_valid",    {29'h0, cv8, cv16, cv32}, 32'h0);
        chk("rst_crc8",     {24'h0, crc8},  32'h0);
        chk("rst_crc32",    crc32,          32'h0);
        @(posedge clk); #1;

        // Table vectors, result port always ready.
        crc_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp8.push_back(tbl[i].e8);
            exp16.push_back(tbl[i].e16);
            exp32.push_back(tbl[i].e32);
            send_bytes(tbl[i].data, tbl[i].n, 1'b1);
        end
        drain();

        // Latency and backpressure in DONE.
        @(posedge clk); #1;
        crc_ready = 1'b0;
        push_model(72'h01, 1);
        data = 8'h01; last = 1'b1; valid = 1'b1;
        @(negedge clk);
        chk("lat_ready", {31'h0, rdy8}, 32'h1);
        @(posedge clk); #1;
        data = 8'h55; last = 1'b0;           // keep offering a byte throughout
        @(negedge clk);
        chk("lat_update_valid", {31'h0, cv8}, 32'h0);
        @(negedge clk);
        chk("lat_done_valid", {31'h0, cv8}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {29'h0, cv8, cv16, cv32}, 32'h7);
            chk("hold_crc8",  {24'h0, crc8}, 32'h07);
            chk("hold_crc32", crc32, m32(72'h01, 1));
            chk("hold_ready", {31'h0, rdy8}, 32'h0);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        crc_ready = 1'b1;
        drain();
        // A stray 0x55 taken during the hold would corrupt this frame.
        push_model(CHK9, 9);
        send_bytes(CHK9, 9, 1'b1);
        drain();

        // Abort mid-frame after "1234", then a clean frame.
        push_model(CHK9, 9);
        send_bytes(72'h34333231, 4, 1'b0);
        @(posedge clk); #1;                  // back in READY
        clear = 1'b1; valid = 1'b1; data = 8'h99; last = 1'b1;
        @(negedge clk);
        chk("clear_ready", {31'h0, rdy8}, 32'h0);
        @(posedge clk); #1;
        clear = 1'b0; valid = 1'b0; last = 1'b0;
        @(negedge clk);
        chk("clear_state", {30'h0, rdy8, cv8}, 32'h2);
        @(posedge clk); #1;
        send_bytes(CHK9, 9, 1'b1);
        drain();

        // Asynchronous reset during UPDATE; the partial frame is dropped.
        send_bytes(72'h31, 1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'h0, rdy8}, 32'h1);
        chk("arst_valid", {31'h0, cv8}, 32'h0);
        chk("arst_crc8",  {24'h0, crc8}, 32'h0);
        chk("arst_crc16", {16'h0, crc16}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_model(CHK9, 9);
        send_bytes(CHK9, 9, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
